// File: rtl/dircc_avalon_st_packet_sender_multi.sv
// Buffers up to FIFO_DEPTH whole packets and serialises them onto an Avalon-ST source.
// Define DIRCC_PKT_SENDER_LAMPORT_EN to stamp W4 of each packet with a running Lamport count.
module dircc_avalon_st_packet_sender_multi #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned PAYLOAD_WORDS = 3,
    parameter int unsigned FIFO_DEPTH    = 2,
    localparam int unsigned PACKET_BITS  = 32 * (5 + PAYLOAD_WORDS),
    localparam int unsigned CNT_W        = $clog2(FIFO_DEPTH) + 1,
    localparam int unsigned EMPTY_W      = (DATA_WIDTH > 16) ? $clog2(DATA_WIDTH / 8) : 1
) (
`ifdef DIRCC_PKT_SENDER_LAMPORT_EN
    output logic [31:0]             lamport_count,
`endif
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [PACKET_BITS-1:0]  packet_data,
    input  logic                    write_packet,
    output logic                    packet_ready,
    output logic                    sending,
    output logic [CNT_W-1:0]        packets_pending,
    output logic [DATA_WIDTH-1:0]   output_data,
    output logic                    output_valid,
    input  logic                    output_ready,
    output logic                    output_startofpacket,
    output logic                    output_endofpacket,
    output logic [EMPTY_W-1:0]      output_empty
);

    localparam int unsigned R         = DATA_WIDTH / 32;
    localparam int unsigned N         = 5 + PAYLOAD_WORDS;
    localparam int unsigned BEATS     = (N + R - 1) / R;
    localparam int unsigned SHREG_W   = BEATS * DATA_WIDTH;
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned EMPTY_VAL = 4 * (BEATS * R - N);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                 state_q, state_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [SHREG_W-1:0]     shreg_q, shreg_d;
    logic [PACKET_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       fifo_cnt_q, fifo_cnt_d;
    logic                   wrote_q;
    logic                   packet_ready_q, packet_ready_d;
    logic [CNT_W:0]         occupancy_d;
    logic                   accept, pop, can_pop;
    logic [SHREG_W-1:0]     load_val;
`ifdef DIRCC_PKT_SENDER_LAMPORT_EN
    logic [31:0]            lamport_q;
`endif

    assign accept = write_packet & packet_ready_q;
    // A packet written on the last edge is not yet visible to the reader, giving the
    // two-edge write-to-sop latency.
    assign can_pop = fifo_cnt_q > CNT_W'(wrote_q);

    always_comb begin
        load_val = '0;
        load_val[PACKET_BITS-1:0] = mem_q[rd_ptr_q];
        load_val[39:32]  = 8'h00;
        load_val[103:96] = 8'h00;
`ifdef DIRCC_PKT_SENDER_LAMPORT_EN
        load_val[159:128] = lamport_q;
`endif
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if (can_pop) begin
                    pop     = 1'b1;
                    state_d = StSend;
                    beat_d  = '0;
                    shreg_d = load_val;
                end
            end
            StSend: begin
                if (output_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d = '0;
                        if (can_pop) begin
                            pop     = 1'b1;
                            shreg_d = load_val;
                        end else begin
                            state_d = StIdle;
                            shreg_d = '0;
                        end
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                        shreg_d = shreg_q >> DATA_WIDTH;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // The in-flight packet keeps its slot until its eop is accepted.
    always_comb begin
        fifo_cnt_d     = fifo_cnt_q + CNT_W'(accept) - CNT_W'(pop);
        occupancy_d    = {1'b0, fifo_cnt_d} + (CNT_W + 1)'(state_d == StSend);
        packet_ready_d = occupancy_d < (CNT_W + 1)'(FIFO_DEPTH);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            beat_q         <= '0;
            shreg_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fifo_cnt_q     <= '0;
            wrote_q        <= 1'b0;
            packet_ready_q <= 1'b1;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            shreg_q        <= shreg_d;
            wr_ptr_q       <= wr_ptr_q + PTR_W'(accept);
            rd_ptr_q       <= rd_ptr_q + PTR_W'(pop);
            fifo_cnt_q     <= fifo_cnt_d;
            wrote_q        <= accept;
            packet_ready_q <= packet_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= packet_data;
        end
    end

`ifdef DIRCC_PKT_SENDER_LAMPORT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lamport_q <= '0;
        end else begin
            lamport_q <= lamport_q + 32'(pop);
        end
    end

    assign lamport_count = lamport_q;
`endif

    assign sending              = (state_q == StSend);
    assign output_valid         = sending;
    assign output_data          = shreg_q[DATA_WIDTH-1:0];
    assign output_startofpacket = sending && (beat_q == '0);
    assign output_endofpacket   = sending && (beat_q == LAST_BEAT);
    assign output_empty         = output_endofpacket ? EMPTY_W'(EMPTY_VAL) : '0;
    assign packet_ready         = packet_ready_q;
    assign packets_pending      = fifo_cnt_q;

endmodule

// File: tb/tb_dircc_avalon_st_packet_sender_multi.sv
// Bench for the multi-packet Avalon-ST sender: a 32-bit default instance and a 64-bit,
// two-payload-word instance, checked against a word-list model of each packet.
module tb_dircc_avalon_st_packet_sender_multi;

`ifdef DIRCC_PKT_SENDER_LAMPORT_EN
    localparam bit LAMP = 1'b1;
`else
    localparam bit LAMP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [255:0] pd32;
    logic         wr32, prdy32, snd32, rdy32, v32, sop32, eop32;
    logic [1:0]   pend32;
    logic [31:0]  od32;
    logic [1:0]   emp32;

    logic [223:0] pd64;
    logic         wr64, prdy64, snd64, rdy64, v64, sop64, eop64;
    logic [2:0]   pend64;
    logic [63:0]  od64;
    logic [2:0]   emp64;

`ifdef DIRCC_PKT_SENDER_LAMPORT_EN
    logic [31:0]  lc32, lc64;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] lam32 = 32'h0;
    logic [31:0] lam64 = 32'h0;

    dircc_avalon_st_packet_sender_multi #(
        .DATA_WIDTH(32), .PAYLOAD_WORDS(3), .FIFO_DEPTH(2)
    ) u_dut32 (
`ifdef DIRCC_PKT_SENDER_LAMPORT_EN
        .lamport_count(lc32),
`endif
        .clk(clk), .reset_n(reset_n), .packet_data(pd32), .write_packet(wr32),
        .packet_ready(prdy32), .sending(snd32), .packets_pending(pend32),
        .output_data(od32), .output_valid(v32), .output_ready(rdy32),
        .output_startofpacket(sop32), .output_endofpacket(eop32), .output_empty(emp32)
    );

    dircc_avalon_st_packet_sender_multi #(
        .DATA_WIDTH(64), .PAYLOAD_WORDS(2), .FIFO_DEPTH(4)
    ) u_dut64 (
`ifdef DIRCC_PKT_SENDER_LAMPORT_EN
        .lamport_count(lc64),
`endif
        .clk(clk), .reset_n(reset_n), .packet_data(pd64), .write_packet(wr64),
        .packet_ready(prdy64), .sending(snd64), .packets_pending(pend64),
        .output_data(od64), .output_valid(v64), .output_ready(rdy64),
        .output_startofpacket(sop64), .output_endofpacket(eop64), .output_empty(emp64)
    );

    // Expected word i of a packet with n words as it should appear on the wire.
    function automatic logic [31:0] exp_word(input logic [255:0] p, input int i, input int n,
                                             input logic [31:0] lam);
        logic [31:0] w;
        if (i >= n) return 32'h0;
        w = p[32*i +: 32];
        if (i == 1 || i == 3) w = w & 32'hFFFF_FF00;
        if (i == 4 && LAMP) w = lam;
        return w;
    endfunction

    function automatic logic [255:0] rand_pkt();
        logic [255:0] p;
        for (int i = 0; i < 8; i++) p[32*i +: 32] = $urandom;
        return p;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        lam32 = 32'h0;
        lam64 = 32'h0;
    endtask

    // Offer one packet and hold it until the DUT takes it.
    task automatic push(input int sel, input logic [255:0] p);
        int  t;
        bit  done;
        t = 0;
        done = 1'b0;
        if (sel == 0) begin pd32 = p; wr32 = 1'b1; end
        else begin pd64 = p[223:0]; wr64 = 1'b1; end
        while (!done && t < 100) begin
            @(negedge clk);
            done = (sel == 0) ? prdy32 : prdy64;
            @(posedge clk);
            #1 t++;
        end
        wr32 = 1'b0;
        wr64 = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL push_accept sel=%0d: packet_ready never seen in %0d cycles", sel, t);
        end
    endtask

    // Collect one packet beat by beat under the given ready pattern and check every beat.
    task automatic recv(input int sel, input logic [255:0] p, input int mode, input bit imm);
        int n, r, beats, k, c, exp_emp, em;
        logic [31:0] lam;
        logic [63:0] d, ed;
        logic v, so, eo, sn, rdy;
        n = (sel == 0) ? 8 : 7;
        r = (sel == 0) ? 1 : 2;
        beats = (n + r - 1) / r;
        lam = (sel == 0) ? lam32 : lam64;
        if (sel == 0) lam32++; else lam64++;
        k = 0;
        c = 0;
        while (k < beats && c < 400) begin
            case (mode)
                0: rdy = 1'b1;
                1: rdy = (c % 4 == 0) || (c % 4 == 3);
                default: rdy = ($urandom_range(0, 1) == 1);
            endcase
            if (sel == 0) rdy32 = rdy; else rdy64 = rdy;
            @(negedge clk);
            if (sel == 0) begin
                v = v32; so = sop32; eo = eop32; sn = snd32; em = int'(emp32); d = {32'h0, od32};
            end else begin
                v = v64; so = sop64; eo = eop64; sn = snd64; em = int'(emp64); d = od64;
            end
            if (c == 0 && imm) begin
                checks++;
                if ({v, so} !== 2'b11) begin
                    errors++;
                    $display("FAIL b2b_sop sel=%0d: valid,sop=%b%b, required 11", sel, v, so);
                end
            end
            if (v) begin
                ed = '0;
                for (int j = 0; j < r; j++) ed[32*j +: 32] = exp_word(p, k*r + j, n, lam);
                exp_emp = (k == beats - 1) ? 4 * (beats * r - n) : 0;
                checks++;
                if (d !== ed) begin
                    errors++;
                    $display("FAIL beat_data sel=%0d beat=%0d: got %h, required %h", sel, k, d, ed);
                end
                checks++;
                if ({so, eo, sn} !== {k == 0, k == beats - 1, 1'b1}) begin
                    errors++;
                    $display("FAIL beat_flags sel=%0d beat=%0d: sop,eop,sending=%b%b%b", sel, k,
                             so, eo, sn);
                end
                checks++;
                if (em !== exp_emp) begin
                    errors++;
                    $display("FAIL beat_empty sel=%0d beat=%0d: got %0d, required %0d", sel, k,
                             em, exp_emp);
                end
                if (rdy) k++;
            end
            @(posedge clk);
            #1 c++;
        end
        rdy32 = 1'b0;
        rdy64 = 1'b0;
        checks++;
        if (k < beats) begin
            errors++;
            $display("FAIL recv_timeout sel=%0d: %0d of %0d beats seen", sel, k, beats);
        end
    endtask

    task automatic check_idle(input int sel);
        @(negedge clk);
        checks++;
        if (sel == 0 && {v32, snd32} !== 2'b00 || sel == 1 && {v64, snd64} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after sel=%0d: valid/sending still high", sel);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit seen_eop, bad;
        @(negedge clk);
        checks++;
        if ({v32, sop32, eop32, snd32, prdy32, pend32, od32, emp32} !== {5'b00001, 36'h0}) begin
            errors++;
            $display("FAIL reset32: v,sop,eop,snd,rdy=%b%b%b%b%b pend=%0d data=%h empty=%0d",
                     v32, sop32, eop32, snd32, prdy32, pend32, od32, emp32);
        end
        checks++;
        if ({v64, sop64, eop64, snd64, prdy64, pend64, od64, emp64} !== {5'b00001, 70'h0}) begin
            errors++;
            $display("FAIL reset64: v,sop,eop,snd,rdy=%b%b%b%b%b pend=%0d data=%h empty=%0d",
                     v64, sop64, eop64, snd64, prdy64, pend64, od64, emp64);
        end
`ifdef DIRCC_PKT_SENDER_LAMPORT_EN
        checks++;
        if (lc32 !== 32'h0) begin
            errors++;
            $display("FAIL reset_lamport: got %h, required 0", lc32);
        end
`endif
        @(posedge clk);
        #1;
        push(0, rand_pkt());
        rdy32 = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        seen_eop = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            seen_eop |= eop32;
            if (i == 1) begin
                checks++;
                if ({v32, snd32, prdy32, pend32} !== 5'b00100) begin
                    errors++;
                    $display("FAIL reset_mid: v,snd,rdy=%b%b%b pend=%0d, required 001 pend=0",
                             v32, snd32, prdy32, pend32);
                end
            end
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        lam32 = 32'h0;
        lam64 = 32'h0;
        checks++;
        if (seen_eop) begin
            errors++;
            $display("FAIL reset_no_eop: eop=1 observed during reset, required none");
        end
        bad = 1'b0;
        repeat (6) begin @(negedge clk); bad |= v32; end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_discard: valid=1 after reset, required partial packet dropped");
        end
        rdy32 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic [255:0] p;
        p = rand_pkt();
        push(0, p);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (v32 !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: valid=%b one edge after accept, required 0", v32);
        end
        @(negedge clk);
        checks++;
        if ({v32, sop32} !== 2'b11) begin
            errors++;
            $display("FAIL latency_sop: valid,sop=%b%b two edges after accept, required 11",
                     v32, sop32);
        end
        @(posedge clk);
        #1;
        recv(0, p, 0, 1'b1);
        check_idle(0);
    endtask

    task automatic test_width64();
        logic [255:0] p;
        p = rand_pkt();
        push(1, p);
        recv(1, p, 0, 1'b0);
        check_idle(1);
    endtask

    task automatic test_backpressure();
        logic [255:0] p;
        for (int sel = 0; sel < 2; sel++) begin
            for (int mode = 1; mode < 3; mode++) begin
                p = rand_pkt();
                push(sel, p);
                recv(sel, p, mode, 1'b0);
            end
        end
    endtask

    task automatic test_fifo_full();
        logic [255:0] p1, p2, p3;
        p1 = rand_pkt();
        p2 = rand_pkt();
        p3 = rand_pkt();
        push(0, p1);
        push(0, p2);
        pd32 = p3;
        wr32 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({prdy32, pend32, snd32} !== 4'b0011) begin
            errors++;
            $display("FAIL fifo_full: rdy=%b pend=%0d sending=%b, required 0,1,1",
                     prdy32, pend32, snd32);
        end
        @(posedge clk);
        #1;
        fork
            begin
                recv(0, p1, 0, 1'b0);
                recv(0, p2, 0, 1'b1);
            end
            begin
                int t;
                t = 0;
                @(negedge clk);
                while (!prdy32 && t < 100) begin @(negedge clk); t++; end
                checks++;
                if ({prdy32, sop32, snd32} !== 3'b111) begin
                    errors++;
                    $display("FAIL slot_free: rdy,sop,sending=%b%b%b, required 111",
                             prdy32, sop32, snd32);
                end
                @(posedge clk);
                #1 wr32 = 1'b0;
            end
        join
        recv(0, p3, 0, 1'b1);
        check_idle(0);
    endtask

    task automatic test_random();
        logic [255:0] q [4];
        int cnt;
        for (int it = 0; it < 4; it++) begin
            for (int sel = 0; sel < 2; sel++) begin
                cnt = $urandom_range(1, (sel == 0) ? 2 : 3);
                for (int i = 0; i < cnt; i++) begin
                    q[i] = rand_pkt();
                    push(sel, q[i]);
                end
                for (int i = 0; i < cnt; i++) recv(sel, q[i], 2, i > 0);
                check_idle(sel);
            end
        end
    endtask

    task automatic test_lamport();
        logic [255:0] p;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            p = rand_pkt();
            p[159:128] = 32'hDEAD_BEEF;
            push(0, p);
            recv(0, p, 0, 1'b0);
        end
`ifdef DIRCC_PKT_SENDER_LAMPORT_EN
        @(negedge clk);
        checks++;
        if (lc32 !== lam32) begin
            errors++;
            $display("FAIL lamport_count: got %0d, required %0d", lc32, lam32);
        end
        @(posedge clk);
        #1;
`endif
    endtask

    initial begin
        pd32 = '0; wr32 = 1'b0; rdy32 = 1'b0;
        pd64 = '0; wr64 = 1'b0; rdy64 = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        test_reset();
        test_single();
        test_width64();
        test_backpressure();
        test_fifo_full();
        test_random();
        test_lamport();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
